// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial deserialiser: word width, modulus
// helper, collector state encoding and bit-counter width.
package bs_pkg;

    localparam int unsigned BS_LEN = 94;

    typedef enum logic {
        IDLE,
        SHIFT
    } bs_state_t;

    // Modulus p = 2^LEN - 3 for the default width.
    function automatic logic [BS_LEN-1:0] bs_p();
        return {BS_LEN{1'b1}} - BS_LEN'(2);
    endfunction

    function automatic int unsigned bs_cnt_w(input int unsigned len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/bsdeser_if.sv
// Parallel valid/ready port carrying one deserialised word.
interface bsdeser_if
    import bs_pkg::*;
#(
    parameter int unsigned LEN = BS_LEN
);

    logic [LEN-1:0] d;
    logic           valid;
    logic           ready;

    modport master (output d, output valid, input ready);
    modport slave  (input d, input valid, output ready);

endinterface

// File: rtl/bsshift_in.sv
// Serial LSB-first collector: shift register, bit counter and IDLE/SHIFT FSM.
// Emits the completed word with a 1-cycle done strobe the cycle after bit LEN-1.
module bsshift_in
    import bs_pkg::*;
#(
    parameter int unsigned LEN = BS_LEN
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           is,
    input  logic           isync,
    output logic [LEN-1:0] w,
    output logic           done
);

    localparam int unsigned CW = bs_cnt_w(LEN);

    bs_state_t      state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [LEN-1:0] sh, sh_nx;
    logic           done_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sh    <= sh_nx;
            done  <= done_nx;
        end
    end

    // isync always wins: it restarts the word even on the completing cycle,
    // which suppresses done for the word being abandoned.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sh_nx    = sh;
        done_nx  = 1'b0;
        if (isync) begin
            sh_nx    = '0;
            sh_nx[0] = is;
            cnt_nx   = CW'(1);
            state_nx = SHIFT;
        end else if (state == SHIFT) begin
            sh_nx[cnt] = is;
            if (cnt == CW'(LEN - 1)) begin
                cnt_nx   = '0;
                state_nx = IDLE;
                done_nx  = 1'b1;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
    end

    assign w = sh;

endmodule

// File: rtl/bsdeser.sv
// Bit-serial to parallel collector with output buffer, valid/ready and sticky overrun.
// Define BSDESER_CANON_EN to reduce each word to canonical form modulo 2^LEN-3.
module bsdeser
    import bs_pkg::*;
#(
    parameter int unsigned LEN = BS_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic is,
    input  logic isync,
    input  logic clr,
    output logic ovf,
    bsdeser_if.master m
);

    logic [LEN-1:0] w;
    logic [LEN-1:0] wc;
    logic           done;
    logic           take;

    bsshift_in #(.LEN(LEN)) u_shift (
        .clk   (clk),
        .reset (reset),
        .is    (is),
        .isync (isync),
        .w     (w),
        .done  (done)
    );

`ifdef BSDESER_CANON_EN
    // w >= p only when bits above 1 are all ones and the low pair is nonzero.
    always_comb begin
        wc = w;
        if ((&w[LEN-1:2]) && (w[1:0] != 2'b00)) begin
            wc = LEN'(w[1:0] - 2'd1);
        end
    end
`else
    assign wc = w;
`endif

    assign take = done && (!m.valid || m.ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m.d     <= '0;
            m.valid <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (take) begin
                m.d     <= wc;
                m.valid <= 1'b1;
            end else if (m.valid && m.ready) begin
                m.valid <= 1'b0;
            end
            if (done && !take) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
